// File: rtl/axilite_master_if.sv
// AXI-Lite bus bundle with master and slave views.
interface axilite #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axilite_master.sv
// Single-outstanding AXI-Lite master: one command in, one completion out,
// with a saturating error counter and a sticky (non-aborting) watchdog.
module axilite_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    m_axi_aclk,
    input  logic                    m_axi_areset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic [15:0]             err_cnt,
    output logic                    timeout,
    axilite.master                  __m_axilite
);
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, RSP} state_t;

    state_t                  r_state;
    logic                    r_cmd_ready;
    logic                    r_write;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_wstrb;
    logic                    r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic                    r_rsp_valid, r_rsp_write;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic [1:0]              r_rsp_resp;
    logic [15:0]             r_err_cnt;
    logic                    r_timeout;
    logic [WD_W-1:0]         r_wdog;

    logic w_waiting, w_aw_done, w_w_done;

    assign w_waiting = (r_state == WR) || (r_state == WB) || (r_state == RA) || (r_state == RD);
    // A channel counts as done if it already handshook or handshakes this cycle.
    assign w_aw_done = !r_awvalid || __m_axilite.awready;
    assign w_w_done  = !r_wvalid  || __m_axilite.wready;

    function automatic logic [15:0] f_err_next(input logic [15:0] cnt, input logic [1:0] resp);
        return ((resp != 2'b00) && (cnt != 16'hFFFF)) ? cnt + 16'd1 : cnt;
    endfunction

    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
            r_err_cnt   <= '0;
            r_timeout   <= 1'b0;
            r_wdog      <= '0;
        end else begin
            // Watchdog only flags; the transaction keeps waiting regardless.
            if (w_waiting) begin
                if (r_wdog != WD_MAX) r_wdog <= r_wdog + 1'b1;
                if (r_wdog == WD_LAST) r_timeout <= 1'b1;
            end else begin
                r_wdog <= '0;
            end

            case (r_state)
                IDLE: begin
                    if (r_cmd_ready && cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_write     <= cmd_write;
                        r_addr      <= cmd_addr;
                        r_wdata     <= cmd_wdata;
                        r_wstrb     <= cmd_wstrb;
                        if (cmd_write) begin
                            r_state   <= WR;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                        end else begin
                            r_state   <= RA;
                            r_arvalid <= 1'b1;
                        end
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                WR: begin
                    if (r_awvalid && __m_axilite.awready) r_awvalid <= 1'b0;
                    if (r_wvalid && __m_axilite.wready)   r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_state  <= WB;
                        r_bready <= 1'b1;
                        r_wdog   <= '0;
                    end
                end
                WB: begin
                    if (__m_axilite.bvalid) begin
                        r_bready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_write <= r_write;
                        r_rsp_rdata <= '0;
                        r_rsp_resp  <= __m_axilite.bresp;
                        r_err_cnt   <= f_err_next(r_err_cnt, __m_axilite.bresp);
                        r_state     <= RSP;
                        r_wdog      <= '0;
                    end
                end
                RA: begin
                    if (__m_axilite.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD;
                        r_wdog    <= '0;
                    end
                end
                RD: begin
                    if (__m_axilite.rvalid) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_write <= r_write;
                        r_rsp_rdata <= __m_axilite.rdata;
                        r_rsp_resp  <= __m_axilite.rresp;
                        r_err_cnt   <= f_err_next(r_err_cnt, __m_axilite.rresp);
                        r_state     <= RSP;
                        r_wdog      <= '0;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_write = r_rsp_write;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_resp  = r_rsp_resp;
    assign err_cnt   = r_err_cnt;
    assign timeout   = r_timeout;

    assign __m_axilite.awaddr  = r_addr;
    assign __m_axilite.awvalid = r_awvalid;
    assign __m_axilite.wdata   = r_wdata;
    assign __m_axilite.wstrb   = r_wstrb;
    assign __m_axilite.wvalid  = r_wvalid;
    assign __m_axilite.bready  = r_bready;
    assign __m_axilite.araddr  = r_addr;
    assign __m_axilite.arvalid = r_arvalid;
    assign __m_axilite.rready  = r_rready;
endmodule

// File: tb/tb_axilite_master.sv
// Directed bench for axilite_master: scripted slave with per-channel delays,
// protocol monitors, and per-scenario tasks with hand-computed expectations.
module tb_axilite_master;
    logic        clk;
    logic        rst;
    logic        cmd_valid, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        cmd_ready;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [15:0] err_cnt;
    logic        timeout;

    int n_vec = 0;
    int n_err = 0;

    axilite #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    axilite_master #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(8)) dut (
        .m_axi_aclk(clk), .m_axi_areset(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_cnt(err_cnt),
        .timeout(timeout), .__m_axilite(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: ready/valid responses after a programmable number of cycles.
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
    logic [31:0] s_rdata = 32'h0;
    int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;

    always @(negedge clk) begin
        if (bus.awvalid) begin bus.awready = (aw_wait >= aw_dly); aw_wait++; end
        else begin bus.awready = 1'b0; aw_wait = 0; end
        if (bus.wvalid) begin bus.wready = (w_wait >= w_dly); w_wait++; end
        else begin bus.wready = 1'b0; w_wait = 0; end
        if (bus.arvalid) begin bus.arready = (ar_wait >= ar_dly); ar_wait++; end
        else begin bus.arready = 1'b0; ar_wait = 0; end
        bus.bresp = s_bresp;
        if (bus.bready) begin bus.bvalid = (b_wait >= b_dly); b_wait++; end
        else begin bus.bvalid = 1'b0; b_wait = 0; end
        bus.rdata = s_rdata;
        bus.rresp = s_rresp;
        if (bus.rready) begin bus.rvalid = (r_wait >= r_dly); r_wait++; end
        else begin bus.rvalid = 1'b0; r_wait = 0; end
    end

    // Handshake counters and captured payloads.
    int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
    logic [7:0]  hs_awaddr, hs_araddr;
    logic [31:0] hs_wdata;
    logic [3:0]  hs_wstrb;
    always @(posedge clk) begin
        if (bus.awvalid && bus.awready) begin n_aw++; hs_awaddr = bus.awaddr; end
        if (bus.wvalid && bus.wready) begin n_w++; hs_wdata = bus.wdata; hs_wstrb = bus.wstrb; end
        if (bus.bvalid && bus.bready) n_b++;
        if (bus.arvalid && bus.arready) begin n_ar++; hs_araddr = bus.araddr; end
        if (bus.rvalid && bus.rready) n_r++;
    end

    // Protocol monitors: payload stability under backpressure, single active channel.
    int n_unstable = 0, n_overlap = 0, n_split = 0;
    logic aw_hold = 1'b0, w_hold = 1'b0, ar_hold = 1'b0;
    logic [7:0]  aw_prev, ar_prev;
    logic [35:0] w_prev;
    always @(posedge clk) begin
        if (rst) begin
            aw_hold = 1'b0; w_hold = 1'b0; ar_hold = 1'b0;
        end else begin
            if (aw_hold && (!bus.awvalid || bus.awaddr !== aw_prev)) n_unstable++;
            if (w_hold && (!bus.wvalid || {bus.wstrb, bus.wdata} !== w_prev)) n_unstable++;
            if (ar_hold && (!bus.arvalid || bus.araddr !== ar_prev)) n_unstable++;
            aw_hold = bus.awvalid && !bus.awready; aw_prev = bus.awaddr;
            w_hold  = bus.wvalid && !bus.wready;   w_prev  = {bus.wstrb, bus.wdata};
            ar_hold = bus.arvalid && !bus.arready; ar_prev = bus.araddr;
        end
    end
    always @(negedge clk) begin
        if (int'(bus.awvalid || bus.wvalid) + int'(bus.bready) + int'(bus.arvalid) + int'(bus.rready) > 1)
            n_overlap++;
        if (!bus.awvalid && bus.wvalid) n_split++;
    end

    task automatic send_cmd(input logic wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        int k;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        n_vec++;
        if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL cmd_accept cmd_ready got %b want 1", cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int k;
        k = 0;
        while (rsp_valid !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        n_vec++;
        if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rsp_wait rsp_valid got %b want 1", rsp_valid); end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_cmd_ready got %b want 0", cmd_ready); end
        n_vec++; if ({rsp_valid, rsp_write, rsp_resp, rsp_rdata} !== 36'h0) begin n_err++; $display("FAIL rst_rsp got %h want 0", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}); end
        n_vec++; if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 5'b0) begin n_err++; $display("FAIL rst_axi_valids got %b want 00000", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}); end
        n_vec++; if ({err_cnt, timeout} !== 17'h0) begin n_err++; $display("FAIL rst_err_timeout got %h want 0", {err_cnt, timeout}); end
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_cmd_ready got %b want 1", cmd_ready); end
    endtask

    task automatic test_write_basic();
        int b_aw, b_w, b_b;
        aw_dly = 0; w_dly = 0; b_dly = 0; s_bresp = 2'b00;
        b_aw = n_aw; b_w = n_w; b_b = n_b;
        send_cmd(1'b1, 8'h10, 32'hA5A5_1234, 4'hF);
        wait_rsp();
        n_vec++; if (rsp_write !== 1'b1) begin n_err++; $display("FAIL wr_rsp_write got %b want 1", rsp_write); end
        n_vec++; if (rsp_resp !== 2'b00) begin n_err++; $display("FAIL wr_rsp_resp got %b want 00", rsp_resp); end
        n_vec++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL wr_rsp_rdata got %h want 0", rsp_rdata); end
        n_vec++; if ({n_aw - b_aw, n_w - b_w, n_b - b_b} !== {32'd1, 32'd1, 32'd1}) begin n_err++; $display("FAIL wr_handshakes got aw=%0d w=%0d b=%0d want 1 1 1", n_aw - b_aw, n_w - b_w, n_b - b_b); end
        n_vec++; if ({hs_awaddr, hs_wdata, hs_wstrb} !== {8'h10, 32'hA5A5_1234, 4'hF}) begin n_err++; $display("FAIL wr_payload got %h %h %h want 10 a5a51234 f", hs_awaddr, hs_wdata, hs_wstrb); end
        finish_rsp();
        n_vec++; if (err_cnt !== 16'd0) begin n_err++; $display("FAIL wr_err_cnt got %0d want 0", err_cnt); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL wr_rsp_consumed got %b want 0", rsp_valid); end
    endtask

    task automatic test_write_split();
        int b_aw, b_w, b_b, b_sp;
        aw_dly = 0; w_dly = 3; b_dly = 0; s_bresp = 2'b00;
        b_aw = n_aw; b_w = n_w; b_b = n_b; b_sp = n_split;
        send_cmd(1'b1, 8'h24, 32'h0000_BEEF, 4'h3);
        wait_rsp();
        n_vec++; if (n_split - b_sp !== 3) begin n_err++; $display("FAIL split_aw_dropped_w_held got %0d cycles want 3", n_split - b_sp); end
        n_vec++; if ({n_aw - b_aw, n_w - b_w, n_b - b_b} !== {32'd1, 32'd1, 32'd1}) begin n_err++; $display("FAIL split_handshakes got aw=%0d w=%0d b=%0d want 1 1 1", n_aw - b_aw, n_w - b_w, n_b - b_b); end
        n_vec++; if ({hs_awaddr, hs_wdata, hs_wstrb} !== {8'h24, 32'h0000_BEEF, 4'h3}) begin n_err++; $display("FAIL split_payload got %h %h %h want 24 0000beef 3", hs_awaddr, hs_wdata, hs_wstrb); end
        finish_rsp();
        w_dly = 0;
    endtask

    task automatic test_read();
        ar_dly = 0; r_dly = 5; s_rdata = 32'hA5A5_1234; s_rresp = 2'b00;
        send_cmd(1'b0, 8'h10, 32'h0, 4'h0);
        wait_rsp();
        n_vec++; if (rsp_rdata !== 32'hA5A5_1234) begin n_err++; $display("FAIL rd_rdata got %h want a5a51234", rsp_rdata); end
        n_vec++; if (rsp_write !== 1'b0) begin n_err++; $display("FAIL rd_rsp_write got %b want 0", rsp_write); end
        n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL rd_timeout got %b want 0", timeout); end
        n_vec++; if (hs_araddr !== 8'h10) begin n_err++; $display("FAIL rd_araddr got %h want 10", hs_araddr); end
        s_rdata = 32'hDEAD_0000;
        repeat (2) @(negedge clk);
        n_vec++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'hA5A5_1234}) begin n_err++; $display("FAIL rd_rsp_hold got %b %h want 1 a5a51234", rsp_valid, rsp_rdata); end
        finish_rsp();
        r_dly = 0;
    endtask

    task automatic test_errors();
        s_bresp = 2'b10;
        send_cmd(1'b1, 8'h04, 32'h1, 4'h1); wait_rsp();
        n_vec++; if ({rsp_resp, rsp_rdata} !== {2'b10, 32'h0}) begin n_err++; $display("FAIL err_wr_resp got %b %h want 10 0", rsp_resp, rsp_rdata); end
        finish_rsp();
        s_rresp = 2'b10; s_rdata = 32'h1111_2222;
        send_cmd(1'b0, 8'h08, 32'h0, 4'h0); wait_rsp(); finish_rsp();
        send_cmd(1'b1, 8'h0C, 32'h2, 4'h2); wait_rsp(); finish_rsp();
        n_vec++; if (err_cnt !== 16'd3) begin n_err++; $display("FAIL err_cnt_three got %0d want 3", err_cnt); end
        @(negedge clk);
        dut.r_err_cnt = 16'hFFFE;
        s_rresp = 2'b11;
        send_cmd(1'b0, 8'h08, 32'h0, 4'h0); wait_rsp();
        n_vec++; if ({err_cnt, rsp_resp} !== {16'hFFFF, 2'b11}) begin n_err++; $display("FAIL err_cnt_reach_max got %h %b want ffff 11", err_cnt, rsp_resp); end
        finish_rsp();
        send_cmd(1'b1, 8'h0C, 32'h3, 4'h4); wait_rsp();
        n_vec++; if (err_cnt !== 16'hFFFF) begin n_err++; $display("FAIL err_cnt_saturate got %h want ffff", err_cnt); end
        finish_rsp();
        s_bresp = 2'b00; s_rresp = 2'b00;
    endtask

    task automatic test_timeout();
        int k;
        b_dly = 20; s_bresp = 2'b00;
        send_cmd(1'b1, 8'h30, 32'hCAFE_F00D, 4'hF);
        k = 0;
        while (bus.bready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        n_vec++; if (bus.bready !== 1'b1) begin n_err++; $display("FAIL to_enter_wb bready got %b want 1", bus.bready); end
        repeat (7) @(negedge clk);
        n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL to_before_limit got %b want 0", timeout); end
        @(negedge clk);
        n_vec++; if (timeout !== 1'b1) begin n_err++; $display("FAIL to_at_limit got %b want 1", timeout); end
        wait_rsp();
        n_vec++; if ({rsp_write, rsp_resp} !== {1'b1, 2'b00}) begin n_err++; $display("FAIL to_completes got %b %b want 1 00", rsp_write, rsp_resp); end
        finish_rsp();
        repeat (3) @(negedge clk);
        n_vec++; if (timeout !== 1'b1) begin n_err++; $display("FAIL to_sticky got %b want 1", timeout); end
        b_dly = 0;
        n_vec++; if (n_unstable !== 0) begin n_err++; $display("FAIL proto_stability got %0d want 0", n_unstable); end
        n_vec++; if (n_overlap !== 0) begin n_err++; $display("FAIL proto_one_channel got %0d want 0", n_overlap); end
    endtask

    task automatic test_reset_mid();
        ar_dly = 60;
        send_cmd(1'b0, 8'h44, 32'h0, 4'h0);
        @(negedge clk);
        n_vec++; if (bus.arvalid !== 1'b1) begin n_err++; $display("FAIL rm_arvalid_before got %b want 1", bus.arvalid); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if ({bus.arvalid, rsp_valid, cmd_ready} !== 3'b000) begin n_err++; $display("FAIL rm_async_clear got %b want 000", {bus.arvalid, rsp_valid, cmd_ready}); end
        n_vec++; if ({err_cnt, timeout} !== 17'h0) begin n_err++; $display("FAIL rm_err_timeout_clear got %h want 0", {err_cnt, timeout}); end
        @(negedge clk);
        rst = 1'b0; ar_dly = 0;
        @(negedge clk);
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rm_cmd_ready_release got %b want 1", cmd_ready); end
        s_rdata = 32'h5A5A_0F0F;
        send_cmd(1'b0, 8'h48, 32'h0, 4'h0); wait_rsp();
        n_vec++; if ({rsp_write, rsp_rdata, hs_araddr} !== {1'b0, 32'h5A5A_0F0F, 8'h48}) begin n_err++; $display("FAIL rm_read_after got %b %h %h want 0 5a5a0f0f 48", rsp_write, rsp_rdata, hs_araddr); end
        finish_rsp();
        n_vec++; if (n_overlap !== 0) begin n_err++; $display("FAIL rm_one_channel got %0d want 0", n_overlap); end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        test_reset();
        test_write_basic();
        test_write_split();
        test_read();
        test_errors();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
